// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared VGA timing definitions.
//   - default 640x480@60 horizontal/vertical timing constants
//   - vga_mode_t: one axis of a mode {active, fp, sync, bp}
//   - mode_total(): total length of an axis (active + porches + sync)
package vga_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 32'd640;
  localparam int unsigned DEF_H_FP     = 32'd16;
  localparam int unsigned DEF_H_SYNC   = 32'd96;
  localparam int unsigned DEF_H_BP     = 32'd48;
  localparam int unsigned DEF_V_ACTIVE = 32'd480;
  localparam int unsigned DEF_V_FP     = 32'd10;
  localparam int unsigned DEF_V_SYNC   = 32'd2;
  localparam int unsigned DEF_V_BP     = 32'd33;
  localparam int unsigned DEF_CNT_W    = 32'd10;

  typedef struct packed {
    int unsigned active;
    int unsigned fp;
    int unsigned sync;
    int unsigned bp;
  } vga_mode_t;

  function automatic int unsigned mode_total(input vga_mode_t m);
    return m.active + m.fp + m.sync + m.bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (horizontal or vertical).
// Ports:
//   Clock    in   clock
//   Reset_n  in   synchronous active-low reset
//   Inc      in   advance the counter by one on this edge
//   Wrap     out  counter sits at its last position (TOTAL-1); combinational
//   Count    out  current position (registered)
//   Blank    out  Count >= ACTIVE (registered)
//   Sync     out  sync pin level, POL while in the sync window (registered)
//   Start    out  one-cycle pulse after an advance that wrapped to 0
// Blank/Sync/Start are decoded from the next count so they line up with Count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Inc,
  output logic             Wrap,
  output logic [CNT_W-1:0] Count,
  output logic             Blank,
  output logic             Sync,
  output logic             Start
);

  localparam vga_mode_t   MODE  = '{active: ACTIVE, fp: FP, sync: SYNC, bp: BP};
  localparam int unsigned TOTAL = mode_total(MODE);

  if ((ACTIVE == 32'd0) || (FP == 32'd0) || (SYNC == 32'd0) || (BP == 32'd0) ||
      (TOTAL > (32'd1 << CNT_W))) begin : g_bad_mode
    $error("vga_axis_counter: zero timing parameter or total exceeds counter range");
  end

  localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(TOTAL - 32'd1);
  localparam logic [CNT_W-1:0] ACTIVE_C  = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_LO_C = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_HI_C = CNT_W'(ACTIVE + FP + SYNC);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(32'd1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             in_sync_s;
  logic             blank_r;
  logic             sync_r;
  logic             start_r;

  assign Wrap  = (count_r == LAST_C);
  assign Count = count_r;
  assign Blank = blank_r;
  assign Sync  = sync_r;
  assign Start = start_r;

  // Next position and sync-window decode of that next position.
  always_comb begin
    count_next_s = count_r;
    if (Inc) begin
      if (Wrap) begin
        count_next_s = {CNT_W{1'b0}};
      end else begin
        count_next_s = count_r + ONE_C;
      end
    end else begin
      count_next_s = count_r;
    end
    in_sync_s = (count_next_s >= SYNC_LO_C) && (count_next_s < SYNC_HI_C);
  end

  // Counter and registered decode; with Inc=0 levels hold and Start drops.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      count_r <= {CNT_W{1'b0}};
      blank_r <= 1'b0;
      sync_r  <= ~POL;
      start_r <= 1'b0;
    end else begin
      count_r <= count_next_s;
      blank_r <= (count_next_s >= ACTIVE_C);
      sync_r  <= in_sync_s ? POL : ~POL;
      start_r <= Inc & Wrap;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with vblank-synchronised
// double-buffer swap.
// Ports:
//   Clock, Reset_n         clock, synchronous active-low reset
//   PxEn                   pixel advance strobe
//   SwapReq                request a display/CPU buffer swap at next vblank
//   NmiEnable              enables Nmi_n while in vblank
//   Col, Row               current raster position
//   HBlank, VBlank         outside the visible area
//   HSync, VSync           sync pin levels (polarity from *_SYNC_POL)
//   FrameStart             one-cycle pulse on entry to (0,0)
//   VBlankStart            one-cycle pulse on entry to (0,V_ACTIVE)
//   BufSel, SwapAck        display buffer select, pulse when it toggles
//   Nmi_n                  ~(NmiEnable & VBlank), registered
// Every output is a flop loaded from next-state values, so all flags describe
// the Col/Row visible in the same cycle.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             PxEn,
  input  logic             SwapReq,
  input  logic             NmiEnable,
  output logic [CNT_W-1:0] Col,
  output logic [CNT_W-1:0] Row,
  output logic             HBlank,
  output logic             VBlank,
  output logic             HSync,
  output logic             VSync,
  output logic             FrameStart,
  output logic             VBlankStart,
  output logic             BufSel,
  output logic             SwapAck,
  output logic             Nmi_n
);

  localparam logic [CNT_W-1:0] V_ACTIVE_C   = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_LAST_ACT_C = CNT_W'(V_ACTIVE - 32'd1);
  localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(32'd1);

  logic             h_wrap_s;
  logic             v_wrap_s;
  logic             v_inc_s;
  logic             h_start_unused_s;  // line-start pulse, not needed at this level
  logic [CNT_W-1:0] row_s;
  logic [CNT_W-1:0] row_next_s;
  logic             vbs_next_s;
  logic             vblank_next_s;
  logic             vbs_r;
  logic             bufsel_r;
  logic             pending_r;
  logic             swap_ack_r;
  logic             nmi_n_r;

  // The row only moves on the pixel that wraps the column.
  assign v_inc_s = PxEn & h_wrap_s;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (H_SYNC_POL),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Inc     (PxEn),
    .Wrap    (h_wrap_s),
    .Count   (Col),
    .Blank   (HBlank),
    .Sync    (HSync),
    .Start   (h_start_unused_s)
  );

  // Vertical wrap to row 0 coincides with the column wrap, i.e. entry to (0,0).
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (V_SYNC_POL),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .Inc     (v_inc_s),
    .Wrap    (v_wrap_s),
    .Count   (row_s),
    .Blank   (VBlank),
    .Sync    (VSync),
    .Start   (FrameStart)
  );

  assign Row         = row_s;
  assign VBlankStart = vbs_r;
  assign BufSel      = bufsel_r;
  assign SwapAck     = swap_ack_r;
  assign Nmi_n       = nmi_n_r;

  // Next row, vblank-entry event and next VBlank level for the Nmi_n flop.
  always_comb begin
    row_next_s = row_s;
    if (v_inc_s) begin
      if (v_wrap_s) begin
        row_next_s = {CNT_W{1'b0}};
      end else begin
        row_next_s = row_s + ONE_C;
      end
    end else begin
      row_next_s = row_s;
    end
    vbs_next_s    = v_inc_s & (row_s == V_LAST_ACT_C);
    vblank_next_s = (row_next_s >= V_ACTIVE_C);
  end

  // Swap arbitration: requests collect in pending; the vblank-entry edge
  // consumes pending (or a request arriving on that very edge) and toggles.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      vbs_r      <= 1'b0;
      bufsel_r   <= 1'b0;
      pending_r  <= 1'b0;
      swap_ack_r <= 1'b0;
      nmi_n_r    <= 1'b1;
    end else begin
      vbs_r   <= vbs_next_s;
      nmi_n_r <= ~(NmiEnable & vblank_next_s);
      if (vbs_next_s && (pending_r || SwapReq)) begin
        bufsel_r   <= ~bufsel_r;
        pending_r  <= 1'b0;
        swap_ack_r <= 1'b1;
      end else begin
        pending_r  <= pending_r | SwapReq;
        swap_ack_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen in a small mode:
// H = 8/2/2/2 (H_TOTAL 14), V = 4/1/1/1 (V_TOTAL 7), both sync polarities high.
// One frame is 14*7 = 98 advances.
module tb_vga_timing_gen;

  localparam int HT = 14;  // 8+2+2+2
  localparam int VT = 7;   // 4+1+1+1
  localparam int VA = 4;

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic       PxEn = 1'b0;
  logic       SwapReq = 1'b0;
  logic       NmiEnable = 1'b0;
  logic [9:0] Col;
  logic [9:0] Row;
  logic       HBlank, VBlank, HSync, VSync, FrameStart, VBlankStart;
  logic       BufSel, SwapAck, Nmi_n;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(10)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .PxEn(PxEn), .SwapReq(SwapReq),
    .NmiEnable(NmiEnable), .Col(Col), .Row(Row), .HBlank(HBlank),
    .VBlank(VBlank), .HSync(HSync), .VSync(VSync), .FrameStart(FrameStart),
    .VBlankStart(VBlankStart), .BufSel(BufSel), .SwapAck(SwapAck), .Nmi_n(Nmi_n)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int col;
    int row;
    bit hb, vb, hs, vs, fs, vbs, bs, ack, nmi;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fs_count = 0;
  int last_fs = -1;
  int last_period = 0;
  int ack_count = 0;

  // reference model state (state after the edge being stimulated)
  int m_col = 0;
  int m_row = 0;
  bit m_bs = 1'b0;
  bit m_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus and push the expected post-edge outputs.
  task automatic step(input bit px, input bit sr, input bit ne, input bit rn);
    exp_t e;
    @(negedge Clock);
    PxEn = px; SwapReq = sr; NmiEnable = ne; Reset_n = rn;
    e.fs = 1'b0; e.vbs = 1'b0; e.ack = 1'b0;
    if (!rn) begin
      m_col = 0; m_row = 0; m_bs = 1'b0; m_pend = 1'b0;
    end else begin
      if (px) begin
        if (m_col == HT - 1) begin
          m_col = 0;
          e.fs  = (m_row == VT - 1);
          e.vbs = (m_row == VA - 1);
          m_row = (m_row == VT - 1) ? 0 : m_row + 1;
        end else begin
          m_col = m_col + 1;
        end
      end
      if (e.vbs && (m_pend || sr)) begin
        m_bs = !m_bs; m_pend = 1'b0; e.ack = 1'b1;
      end else begin
        m_pend = m_pend | sr;
      end
    end
    e.col = m_col;
    e.row = m_row;
    e.hb  = rn && (m_col >= 8);
    e.vb  = rn && (m_row >= 4);
    e.hs  = rn && (m_col >= 10) && (m_col < 12);
    e.vs  = rn && (m_row == 5);
    e.bs  = m_bs;
    e.nmi = !(rn && ne && (m_row >= 4));
    exp_q.push_back(e);
  endtask

  // Run with PxEn=1 until the model sits at (col,row); bounded.
  task automatic run_to(input int col, input int row, input bit ne);
    int guard = 0;
    while (!(m_col == col && m_row == row) && guard < 300) begin
      step(1'b1, 1'b0, ne, 1'b1);
      guard++;
    end
    if (guard >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL run_to timeout: got guard %0d expected < 300", guard);
    end
  endtask

  task automatic settle();
    @(posedge Clock);
    #2;
  endtask

  // Monitor: each edge the DUT presents a new output set; compare to the queue head.
  always @(posedge Clock) begin
    exp_t e;
    #1;
    cyc++;
    if (FrameStart === 1'b1) begin
      fs_count++;
      if (last_fs >= 0) last_period = cyc - last_fs;
      last_fs = cyc;
    end
    if (SwapAck === 1'b1) ack_count++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("Col", Col, e.col);
      chk("Row", Row, e.row);
      chk("HBlank", HBlank, e.hb);
      chk("VBlank", VBlank, e.vb);
      chk("HSync", HSync, e.hs);
      chk("VSync", VSync, e.vs);
      chk("FrameStart", FrameStart, e.fs);
      chk("VBlankStart", VBlankStart, e.vbs);
      chk("BufSel", BufSel, e.bs);
      chk("SwapAck", SwapAck, e.ack);
      chk("Nmi_n", Nmi_n, e.nmi);
    end
  end

  initial begin
    int fs0;
    int ack0;

    // reset
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // free run: 220 advances -> FrameStart after 98 and 196 advances
    fs0 = fs_count;
    for (int i = 0; i < 220; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    settle();
    chk("frames_free_run", fs_count - fs0, 2);
    chk("period_free_run", last_period, 98);

    // PxEn 1,0,1,0: 210 advances from offset 24 -> two frames 196 cycles apart
    fs0 = fs_count;
    for (int i = 0; i < 420; i++) step(((i % 2) == 0), 1'b0, (((i / 37) % 2) == 0), 1'b1);
    settle();
    chk("frames_toggle", fs_count - fs0, 2);
    chk("period_toggle", last_period, 196);

    // two requests in one frame -> one swap at the next vblank, none after
    run_to(0, 1, 1'b0);
    ack0 = ack_count;
    step(1'b1, 1'b1, 1'b0, 1'b1);
    run_to(0, 2, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 196; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    chk("acks_collapsed", ack_count - ack0, 1);
    chk("bufsel_after_swap", BufSel, 1);

    // request on the vblank-entry edge is honoured in that vblank
    run_to(HT - 1, VA - 1, 1'b1);
    ack0 = ack_count;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    settle();
    chk("ack_same_edge", ack_count - ack0, 1);

    // request at row 5 (inside vblank) waits for the next frame's vblank
    run_to(0, 5, 1'b1);
    ack0 = ack_count;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    run_to(HT - 1, VA - 1, 1'b1);
    settle();
    chk("ack_deferred_not_yet", ack_count - ack0, 0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    settle();
    chk("ack_deferred_taken", ack_count - ack0, 1);

    // bring BufSel back to 0, then reset with a swap pending
    run_to(0, 1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    run_to(0, 6, 1'b0);
    run_to(0, 1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    run_to(5, 2, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    settle();
    chk("col_after_reset", Col, 0);
    chk("row_after_reset", Row, 0);
    ack0 = ack_count;
    for (int i = 0; i < 196; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    settle();
    chk("no_ack_after_reset", ack_count - ack0, 0);
    chk("bufsel_after_reset", BufSel, 0);

    // hold with PxEn=0
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 column/row counter and sync/blank logic of the framebuffer.
- Generates Col/Row, HSync/VSync and HBlank/VBlank for any VGA mode, advancing on a pixel-enable strobe.
- Adds one-cycle frame and vblank event pulses, and a vblank-synchronised double-buffer swap so CPU writes never tear.
- Sits between the pixel clock domain and the Memory/ConfigReg/Dac path.

Parameters:
- H_ACTIVE, 640, visible columns
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible rows
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_SYNC_POL, 0, HSync asserted level (0 = active low)
- V_SYNC_POL, 0, VSync asserted level (0 = active low)
- CNT_W, 10, width of Col/Row

Ports:
- Clock  in  1  system clock
- Reset_n  in  1  synchronous active-low reset
- PxEn  in  1  pixel advance strobe; counters move only when 1
- SwapReq  in  1  request to swap display/CPU buffers at next vblank
- NmiEnable  in  1  enables Nmi_n during vblank
- Col  out  CNT_W  current column
- Row  out  CNT_W  current row
- HBlank  out  1  Col >= H_ACTIVE
- VBlank  out  1  Row >= V_ACTIVE
- HSync  out  1  horizontal sync pin level
- VSync  out  1  vertical sync pin level
- FrameStart  out  1  one-cycle pulse on entry to (0,0)
- VBlankStart  out  1  one-cycle pulse on entry to (0,V_ACTIVE)
- BufSel  out  1  selects display buffer; CPU owns the other buffer
- SwapAck  out  1  one-cycle pulse when BufSel toggles
- Nmi_n  out  1  ~(NmiEnable & VBlank)

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Elaboration error if any parameter is 0 or either total exceeds 2^CNT_W.
- Reset (Reset_n=0 at a rising edge):
  - Col=0, Row=0.
  - HBlank=0, VBlank=0.
  - HSync=~H_SYNC_POL, VSync=~V_SYNC_POL.
  - FrameStart=0, VBlankStart=0, SwapAck=0.
  - BufSel=0, swap-pending=0.
  - Reset mid-frame takes effect at that edge; any pending swap is discarded.
- Advance, on an edge with PxEn=1:
  - Col increments.
  - Col=H_TOTAL-1 wraps to 0 and Row increments.
  - Row=V_TOTAL-1 at the column wrap wraps to 0.
  - PxEn=0: all counters and level outputs hold; pulses deassert.
- Decode:
  - All outputs are registered, computed from next-state counters, so flags are valid in the same cycle as the Col/Row they describe. Zero relative latency.
  - HSync asserted iff H_ACTIVE+H_FP <= Col < H_ACTIVE+H_FP+H_SYNC.
  - VSync asserted iff V_ACTIVE+V_FP <= Row < V_ACTIVE+V_FP+V_SYNC.
  - VSync changes only on the column wrap.
- Pulses:
  - FrameStart is 1 for exactly the first cycle after an advance into (0,0); it is not asserted out of reset.
  - VBlankStart is 1 for the first cycle after an advance into (0,V_ACTIVE).
- Swap:
  - SwapReq=1 on any edge sets pending.
  - On the edge that produces VBlankStart: if pending or SwapReq, BufSel toggles, pending clears and SwapAck pulses concurrently with VBlankStart.
  - Multiple requests within one frame collapse to one swap.
  - A request on the same edge as VBlankStart is honoured in that vblank.
- Nmi_n is registered and follows VBlank/NmiEnable with the same timing as VBlank.

Decomposition:
- vga_timing_pkg holds:
  - default 640x480@60 timing constants
  - a mode struct typedef {active, fp, sync, bp}
  - a function computing the total
- Sub-module vga_axis_counter (params ACTIVE/FP/SYNC/BP/POL/CNT_W; ports: Clock, Reset_n, Inc, Wrap out, Count, Blank, Sync, Start pulse) is instantiated twice:
  - horizontal: Inc=PxEn
  - vertical: Inc=PxEn & horizontal wrap

Test Plan:
- Defaults, PxEn=1 for 420000 cycles -> exactly one FrameStart per 420000 cycles; HSync=0 exactly for Col 656..751; VSync=0 exactly for Row 490..491; HBlank=1 for Col 640..799.
- PxEn toggling 1,0,1,0 -> Col advances every other cycle; frame period 840000 cycles; pulses remain one cycle wide.
- SwapReq pulses at Row=10 and Row=200 -> single BufSel 0->1 with SwapAck coincident with VBlankStart at (0,480); no toggle in the following frame.
- SwapReq on the VBlankStart edge -> swap occurs in that vblank; SwapReq at Row=481 -> swap deferred to the next frame.
- Reset_n=0 one cycle at (300,200) with a swap pending -> next cycle Col=0, Row=0, BufSel unchanged, no SwapAck in the following vblank.
- Small mode H=8/2/2/2, V=4/1/1/1, POL=1 -> H_TOTAL=14, V_TOTAL=7; HSync=1 at Col 10..11; VSync=1 at Row 5; Nmi_n=0 for Row 4..6 only when NmiEnable=1.
